// File: rtl/instruction_decode_if.sv
// IF/ID -> ID -> ID/EX bus of the MIPS decode stage, plus the WB write port into the register file.
// The master side is the surrounding pipeline; the slave side is the ID stage itself.
interface instruction_decode_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
);
    logic [31:0]       instruction_if_id;
    logic [DATA_W-1:0] next_address_if_id;
    logic              flush;
    logic              wb_reg_write;
    logic [RA_W-1:0]   wb_write_register;
    logic [DATA_W-1:0] wb_write_data;

    logic              stall;
    logic              illegal_opcode;
    logic [DATA_W-1:0] read_data_1_id_ex;
    logic [DATA_W-1:0] read_data_2_id_ex;
    logic [DATA_W-1:0] extended_branch_offset_id_ex;
    logic [DATA_W-1:0] supposed_next_address_id_ex;
    logic [RA_W-1:0]   next_instruction_20_16_id_ex;
    logic [RA_W-1:0]   next_instruction_15_11_id_ex;
    logic [1:0]        ctrl_aluOp_id_ex;
    logic              ctrl_aluSrc_id_ex;
    logic              ctrl_regDest_id_ex;
    logic              ctrl_memRead_id_ex;
    logic              ctrl_memWrite_id_ex;
    logic              ctrl_branch_id_ex;
    logic              ctrl_regWrite_id_ex;
    logic              ctrl_memToReg_id_ex;

    modport master (
        output instruction_if_id, next_address_if_id, flush,
               wb_reg_write, wb_write_register, wb_write_data,
        input  stall, illegal_opcode, read_data_1_id_ex, read_data_2_id_ex,
               extended_branch_offset_id_ex, supposed_next_address_id_ex,
               next_instruction_20_16_id_ex, next_instruction_15_11_id_ex,
               ctrl_aluOp_id_ex, ctrl_aluSrc_id_ex, ctrl_regDest_id_ex,
               ctrl_memRead_id_ex, ctrl_memWrite_id_ex, ctrl_branch_id_ex,
               ctrl_regWrite_id_ex, ctrl_memToReg_id_ex
    );

    modport slave (
        input  instruction_if_id, next_address_if_id, flush,
               wb_reg_write, wb_write_register, wb_write_data,
        output stall, illegal_opcode, read_data_1_id_ex, read_data_2_id_ex,
               extended_branch_offset_id_ex, supposed_next_address_id_ex,
               next_instruction_20_16_id_ex, next_instruction_15_11_id_ex,
               ctrl_aluOp_id_ex, ctrl_aluSrc_id_ex, ctrl_regDest_id_ex,
               ctrl_memRead_id_ex, ctrl_memWrite_id_ex, ctrl_branch_id_ex,
               ctrl_regWrite_id_ex, ctrl_memToReg_id_ex
    );
endinterface

// File: rtl/instruction_decode.sv
// MIPS ID stage: decode, register file, load-use stall and flush bubbles into the ID/EX register.
// Optional REGFILE_BYPASS_EN forwards a same-cycle WB write to the read ports.
module instruction_decode #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int RA_W   = 5
) (
    input logic            clk,
    input logic            reset,
    instruction_decode_if.slave bus
);

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_dest;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [5:0]        opcode;
    logic [RA_W-1:0]   rs, rt, rd;
    logic [DATA_W-1:0] rf_rd1, rf_rd2, rd1, rd2, ext_imm;
    logic [DATA_W-1:0] regs [NREGS];
    ctrl_t             ctrl;
    logic              illegal;
    logic              bubble;

    assign opcode  = bus.instruction_if_id[31:26];
    assign rs      = bus.instruction_if_id[25:21];
    assign rt      = bus.instruction_if_id[20:16];
    assign rd      = bus.instruction_if_id[15:11];
    assign ext_imm = {{(DATA_W-16){bus.instruction_if_id[15]}}, bus.instruction_if_id[15:0]};

    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin ctrl.reg_dest = 1'b1; ctrl.alu_op = 2'b10; ctrl.reg_write = 1'b1; end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            OP_SW:   begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; end
            OP_BEQ:  begin ctrl.alu_op = 2'b01; ctrl.branch = 1'b1; end
            OP_ADDI: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            default: illegal = 1'b1;
        endcase
    end

    assign rf_rd1 = (rs == '0) ? '0 : regs[rs];
    assign rf_rd2 = (rt == '0) ? '0 : regs[rt];

`ifdef REGFILE_BYPASS_EN
    logic wb_live;
    assign wb_live = bus.wb_reg_write && (bus.wb_write_register != '0);
    assign rd1 = (wb_live && bus.wb_write_register == rs) ? bus.wb_write_data : rf_rd1;
    assign rd2 = (wb_live && bus.wb_write_register == rt) ? bus.wb_write_data : rf_rd2;
`else
    assign rd1 = rf_rd1;
    assign rd2 = rf_rd2;
`endif

    // Flush has priority: a squashed instruction must never hold the pipeline.
    assign bus.stall = !bus.flush && bus.ctrl_memRead_id_ex &&
                       (bus.next_instruction_20_16_id_ex != '0) &&
                       ((bus.next_instruction_20_16_id_ex == rs) ||
                        (bus.next_instruction_20_16_id_ex == rt));
    assign bubble    = bus.stall || bus.flush;

    // NOTE: the register array is cleared by the async reset because software relies on it reading 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (bus.wb_reg_write && bus.wb_write_register != '0) begin
            regs[bus.wb_write_register] <= bus.wb_write_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.illegal_opcode               <= 1'b0;
            bus.read_data_1_id_ex            <= '0;
            bus.read_data_2_id_ex            <= '0;
            bus.extended_branch_offset_id_ex <= '0;
            bus.supposed_next_address_id_ex  <= '0;
            bus.next_instruction_20_16_id_ex <= '0;
            bus.next_instruction_15_11_id_ex <= '0;
            bus.ctrl_aluOp_id_ex             <= '0;
            bus.ctrl_aluSrc_id_ex            <= 1'b0;
            bus.ctrl_regDest_id_ex           <= 1'b0;
            bus.ctrl_memRead_id_ex           <= 1'b0;
            bus.ctrl_memWrite_id_ex          <= 1'b0;
            bus.ctrl_branch_id_ex            <= 1'b0;
            bus.ctrl_regWrite_id_ex          <= 1'b0;
            bus.ctrl_memToReg_id_ex          <= 1'b0;
        end else begin
            bus.illegal_opcode               <= illegal && !bubble;
            bus.read_data_1_id_ex            <= rd1;
            bus.read_data_2_id_ex            <= rd2;
            bus.extended_branch_offset_id_ex <= ext_imm;
            bus.supposed_next_address_id_ex  <= bus.next_address_if_id;
            bus.next_instruction_20_16_id_ex <= rt;
            bus.next_instruction_15_11_id_ex <= rd;
            bus.ctrl_aluOp_id_ex             <= bubble ? 2'b00 : ctrl.alu_op;
            bus.ctrl_aluSrc_id_ex            <= ctrl.alu_src    && !bubble;
            bus.ctrl_regDest_id_ex           <= ctrl.reg_dest   && !bubble;
            bus.ctrl_memRead_id_ex           <= ctrl.mem_read   && !bubble;
            bus.ctrl_memWrite_id_ex          <= ctrl.mem_write  && !bubble;
            bus.ctrl_branch_id_ex            <= ctrl.branch     && !bubble;
            bus.ctrl_regWrite_id_ex          <= ctrl.reg_write  && !bubble;
            bus.ctrl_memToReg_id_ex          <= ctrl.mem_to_reg && !bubble;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode: decode, regfile, load-use stall, flush and reset.
module tb_instruction_decode;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    instruction_decode_if bus ();

    instruction_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {aluOp, aluSrc, regDest, memRead, memWrite, branch, regWrite, memToReg}
    localparam logic [8:0] C_NONE = 9'b00_0_0_0_0_0_0_0;
    localparam logic [8:0] C_R    = 9'b10_0_1_0_0_0_1_0;
    localparam logic [8:0] C_LW   = 9'b00_1_0_1_0_0_1_1;
    localparam logic [8:0] C_SW   = 9'b00_1_0_0_1_0_0_0;
    localparam logic [8:0] C_BEQ  = 9'b01_0_0_0_0_1_0_0;
    localparam logic [8:0] C_ADDI = 9'b00_1_0_0_0_0_1_0;

    function automatic logic [8:0] ctrl_bits();
        return {bus.ctrl_aluOp_id_ex, bus.ctrl_aluSrc_id_ex, bus.ctrl_regDest_id_ex,
                bus.ctrl_memRead_id_ex, bus.ctrl_memWrite_id_ex, bus.ctrl_branch_id_ex,
                bus.ctrl_regWrite_id_ex, bus.ctrl_memToReg_id_ex};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
        bus.wb_reg_write      = 1'b1;
        bus.wb_write_register = addr;
        bus.wb_write_data     = data;
        tick();
        bus.wb_reg_write      = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset                  = 1'b0;
        bus.instruction_if_id  = 32'h0;
        bus.next_address_if_id = 32'h0;
        bus.flush              = 1'b0;
        bus.wb_reg_write       = 1'b0;
        bus.wb_write_register  = 5'd0;
        bus.wb_write_data      = 32'h0;

        repeat (2) tick();
        check("rst_ctrl",    {23'h0, ctrl_bits()}, {23'h0, C_NONE});
        check("rst_rd1",     bus.read_data_1_id_ex, 32'h0);
        check("rst_offset",  bus.extended_branch_offset_id_ex, 32'h0);
        check("rst_illegal", {31'h0, bus.illegal_opcode}, 32'h0);
        check("rst_stall",   {31'h0, bus.stall}, 32'h0);
        reset = 1'b1;

        // add r10,r8,r9
        wb_write(5'd8, 32'h0000_0005);
        wb_write(5'd9, 32'h0000_0003);
        bus.instruction_if_id  = 32'h0109_5020;
        bus.next_address_if_id = 32'h0000_0104;
        tick();
        check("add_rd1",    bus.read_data_1_id_ex, 32'h0000_0005);
        check("add_rd2",    bus.read_data_2_id_ex, 32'h0000_0003);
        check("add_rd",     {27'h0, bus.next_instruction_15_11_id_ex}, 32'd10);
        check("add_rt",     {27'h0, bus.next_instruction_20_16_id_ex}, 32'd9);
        check("add_ctrl",   {23'h0, ctrl_bits()}, {23'h0, C_R});
        check("add_offset", bus.extended_branch_offset_id_ex, 32'h0000_5020);
        check("add_pc4",    bus.supposed_next_address_id_ex, 32'h0000_0104);

        // sw r2,8(r1) and addi r3,r1,7
        bus.instruction_if_id = 32'hAC22_0008;
        tick();
        check("sw_ctrl", {23'h0, ctrl_bits()}, {23'h0, C_SW});
        bus.instruction_if_id = 32'h2023_0007;
        tick();
        check("addi_ctrl",   {23'h0, ctrl_bits()}, {23'h0, C_ADDI});
        check("addi_offset", bus.extended_branch_offset_id_ex, 32'h0000_0007);

        // lw r2,-4(r1) followed by add r3,r2,r2
        bus.instruction_if_id = 32'h8C22_FFFC;
        tick();
        check("lw_ctrl",   {23'h0, ctrl_bits()}, {23'h0, C_LW});
        check("lw_offset", bus.extended_branch_offset_id_ex, 32'hFFFF_FFFC);
        bus.instruction_if_id = 32'h0042_1820;
        #1;
        check("lu_stall", {31'h0, bus.stall}, 32'h1);
        tick();
        check("lu_bubble",     {23'h0, ctrl_bits()}, {23'h0, C_NONE});
        check("lu_bubble_rd",  {27'h0, bus.next_instruction_15_11_id_ex}, 32'd3);
        check("lu_stall_drop", {31'h0, bus.stall}, 32'h0);
        tick();
        check("lu_add_ctrl", {23'h0, ctrl_bits()}, {23'h0, C_R});

        // beq r2,r5 behind lw r2 with flush: flush wins
        bus.instruction_if_id = 32'h8C22_FFFC;
        tick();
        bus.instruction_if_id = 32'h1045_0003;
        bus.flush             = 1'b1;
        #1;
        check("flush_stall", {31'h0, bus.stall}, 32'h0);
        tick();
        check("flush_ctrl",    {23'h0, ctrl_bits()}, {23'h0, C_NONE});
        check("flush_illegal", {31'h0, bus.illegal_opcode}, 32'h0);
        tick();
        check("flush_only_ctrl", {23'h0, ctrl_bits()}, {23'h0, C_NONE});
        bus.flush = 1'b0;
        tick();
        check("beq_ctrl",   {23'h0, ctrl_bits()}, {23'h0, C_BEQ});
        check("beq_offset", bus.extended_branch_offset_id_ex, 32'h0000_0003);

        // r0 stays zero; illegal opcode
        wb_write(5'd0, 32'hFFFF_FFFF);
        bus.instruction_if_id = 32'h0000_1020;
        tick();
        check("r0_rd1", bus.read_data_1_id_ex, 32'h0);
        check("r0_rd2", bus.read_data_2_id_ex, 32'h0);
        bus.instruction_if_id = 32'hFC00_0000;
        tick();
        check("ill_flag", {31'h0, bus.illegal_opcode}, 32'h1);
        check("ill_ctrl", {23'h0, ctrl_bits()}, {23'h0, C_NONE});
        bus.instruction_if_id = 32'h0000_0000;
        tick();
        check("ill_clear", {31'h0, bus.illegal_opcode}, 32'h0);

        // WB write to r4 in the same cycle ID reads r4 (add r5,r4,r0)
        wb_write(5'd4, 32'h1111_1111);
        bus.instruction_if_id = 32'h0080_2820;
        bus.wb_reg_write      = 1'b1;
        bus.wb_write_register = 5'd4;
        bus.wb_write_data     = 32'hA5A5_A5A5;
        tick();
        bus.wb_reg_write = 1'b0;
`ifdef REGFILE_BYPASS_EN
        check("wb_same_cycle", bus.read_data_1_id_ex, 32'hA5A5_A5A5);
`else
        check("wb_same_cycle", bus.read_data_1_id_ex, 32'h1111_1111);
`endif
        tick();
        check("wb_next_cycle", bus.read_data_1_id_ex, 32'hA5A5_A5A5);

        // Reset mid-run while a load-use stall is active
        bus.instruction_if_id = 32'h8C22_FFFC;
        tick();
        bus.instruction_if_id = 32'h0042_1820;
        #1;
        check("mid_stall_pre", {31'h0, bus.stall}, 32'h1);
        reset = 1'b0;
        #1;
        check("mid_stall",  {31'h0, bus.stall}, 32'h0);
        check("mid_ctrl",   {23'h0, ctrl_bits()}, {23'h0, C_NONE});
        check("mid_offset", bus.extended_branch_offset_id_ex, 32'h0);
        check("mid_rt",     {27'h0, bus.next_instruction_20_16_id_ex}, 32'd0);
        reset = 1'b1;
        bus.instruction_if_id = 32'h0109_5020;
        tick();
        check("mid_r8", bus.read_data_1_id_ex, 32'h0);
        check("mid_r9", bus.read_data_2_id_ex, 32'h0);
        bus.instruction_if_id = 32'h0080_2820;
        tick();
        check("mid_r4", bus.read_data_1_id_ex, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
